// File: rtl/serial_divide_seq.sv
// Multi-cycle non-restoring divider, one quotient bit per clock, with optional
// two's-complement operands handled by magnitude conversion and sign fix-up.
module serial_divide_seq #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             zeroflag
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on the accepting edge
  // LOAD  | take magnitudes and record signs; divide-by-zero short-cut
  // CALC  | WIDTH non-restoring steps
  // FIX   | remainder correction and sign restoration
  // DONE  | single-cycle result strobe
  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sgn;
  logic [WIDTH-1:0] q, d;
  logic [WIDTH:0]   p;
  logic [CW-1:0]    cnt;
  logic             sign_q, sign_r;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   p_sh, d_ext, p_step;
  logic [WIDTH-1:0] q_step, rem_mag;
  logic             last_step, div_zero;

  assign neg_a     = sgn & a_reg[WIDTH-1];
  assign neg_b     = sgn & b_reg[WIDTH-1];
  assign a_mag     = neg_a ? -a_reg : a_reg;
  assign b_mag     = neg_b ? -b_reg : b_reg;
  assign div_zero  = (b_reg == '0);
  assign last_step = (cnt == CW'(WIDTH - 1));

  // Direction of each step depends on the sign of p before the shift.
  assign d_ext   = {1'b0, d};
  assign p_sh    = {p[WIDTH-1:0], q[WIDTH-1]};
  assign p_step  = p[WIDTH] ? (p_sh + d_ext) : (p_sh - d_ext);
  assign q_step  = {q[WIDTH-2:0], ~p_step[WIDTH]};
  assign rem_mag = p[WIDTH] ? (p[WIDTH-1:0] + d) : p[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: state_nxt = div_zero ? S_DONE : S_CALC;
      S_CALC: if (last_step) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_LOAD, S_CALC, S_FIX: busy = 1'b1;
      S_DONE:                done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sgn       <= 1'b0;
      q         <= '0;
      d         <= '0;
      p         <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      zeroflag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= dividend;
            b_reg <= divisor;
            sgn   <= SIGNED_EN & is_signed;
          end
        end
        S_LOAD: begin
          q      <= a_mag;
          d      <= b_mag;
          p      <= '0;
          cnt    <= '0;
          sign_q <= neg_a ^ neg_b;
          sign_r <= neg_a;
          if (div_zero) begin
            quotient  <= '1;
            remainder <= a_reg;
            zeroflag  <= 1'b1;
          end
        end
        S_CALC: begin
          p <= p_step;
          q <= q_step;
          if (!last_step) cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          // Most-negative / -1 wraps naturally through the negation.
          quotient  <= sign_q ? -q : q;
          remainder <= sign_r ? -rem_mag : rem_mag;
          zeroflag  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
